// File: rtl/cdb_rr_arbiter.sv
// Multi-lane common-data-bus arbiter: picks up to N_LANES ready sources per
// cycle in round-robin (or fixed) order and registers them onto the CDB lanes.
module cdb_rr_arbiter #(
    parameter int N_SRC   = 4,
    parameter int N_LANES = 1,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 16,
    parameter bit RR_EN   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [N_SRC-1:0]            src_valid,
    input  logic [N_SRC*TAG_W-1:0]      src_tag,
    input  logic [N_SRC*DATA_W-1:0]     src_data,
    output logic [N_SRC-1:0]            src_grant,
    output logic [N_LANES-1:0]          cdb_valid,
    output logic [N_LANES*TAG_W-1:0]    cdb_tag,
    output logic [N_LANES*DATA_W-1:0]   cdb_data
);

    localparam int PW = $clog2(N_SRC);

    logic [PW-1:0]             rr_q, rr_d;
    logic [N_LANES-1:0]        lv_q, lv_d;
    logic [N_LANES*TAG_W-1:0]  lt_q, lt_d;
    logic [N_LANES*DATA_W-1:0] ld_q, ld_d;
    logic [N_SRC-1:0]          grant;

    always_comb begin
        int idx;
        int cnt;
        int nxt;
        grant = '0;
        lv_d  = '0;
        lt_d  = '0;
        ld_d  = '0;
        rr_d  = rr_q;
        cnt   = 0;
        idx   = 0;
        nxt   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (RR_EN ? int'(rr_q) : 0) + k;
            // explicit wrap so non-power-of-two source counts scan correctly
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (rst_n && !flush && src_valid[idx] && cnt < N_LANES) begin
                grant[idx] = 1'b1;
                lv_d[cnt]  = 1'b1;
                lt_d[cnt*TAG_W +: TAG_W]   = src_tag[idx*TAG_W +: TAG_W];
                ld_d[cnt*DATA_W +: DATA_W] = src_data[idx*DATA_W +: DATA_W];
                cnt = cnt + 1;
                nxt = idx + 1;
                if (nxt >= N_SRC) nxt = 0;
                if (RR_EN) rr_d = PW'(nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
            lv_q <= '0;
            lt_q <= '0;
            ld_q <= '0;
        end else begin
            rr_q <= rr_d;
            lv_q <= lv_d;
            lt_q <= lt_d;
            ld_q <= ld_d;
        end
    end

    assign src_grant = grant;
    assign cdb_valid = lv_q;
    assign cdb_tag   = lt_q;
    assign cdb_data  = ld_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter: vector table with a lane scoreboard, plus
// reset/fixed-priority corner sequences.
module tb_cdb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [3:0]  src_valid;
    logic [15:0] src_tag;
    logic [63:0] src_data;
    logic [3:0]  src_grant, fx_grant;
    logic [1:0]  cdb_valid, fx_valid;
    logic [7:0]  cdb_tag, fx_tag;
    logic [31:0] cdb_data, fx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_rr_arbiter #(.N_SRC(4), .N_LANES(2), .TAG_W(4), .DATA_W(16), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_grant(src_grant), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data));

    cdb_rr_arbiter #(.N_SRC(4), .N_LANES(2), .TAG_W(4), .DATA_W(16), .RR_EN(1'b0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_grant(fx_grant), .cdb_valid(fx_valid),
        .cdb_tag(fx_tag), .cdb_data(fx_data));

    typedef struct {
        logic [3:0] v;
        logic       fl;
        logic [3:0] g;
        logic [3:0] gf;
        int         l0;
        int         l1;
    } vec_t;

    typedef struct {
        logic [1:0]  v;
        logic [7:0]  t;
        logic [31:0] d;
    } lane_t;

    vec_t  tbl[13];
    lane_t sbq[$];
    logic [3:0]  tg[4];
    logic [15:0] dt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop_lanes(input int step);
        lane_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty step=%0d actual=0 required=1", step);
        end else begin
            e = sbq.pop_front();
            check($sformatf("lane_valid[%0d]", step), 32'(cdb_valid), 32'(e.v));
            check($sformatf("lane_tag[%0d]", step), 32'(cdb_tag), 32'(e.t));
            check($sformatf("lane_data[%0d]", step), cdb_data, e.d);
        end
    endtask

    initial begin
        lane_t e;
        tbl[0]  = '{4'hF, 1'b0, 4'b0011, 4'b0011,  0,  1};
        tbl[1]  = '{4'hF, 1'b0, 4'b1100, 4'b0011,  2,  3};
        tbl[2]  = '{4'hF, 1'b0, 4'b0011, 4'b0011,  0,  1};
        tbl[3]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, -1, -1};
        tbl[4]  = '{4'h0, 1'b0, 4'b0000, 4'b0000, -1, -1};
        tbl[5]  = '{4'h4, 1'b0, 4'b0100, 4'b0100,  2, -1};
        tbl[6]  = '{4'h9, 1'b0, 4'b1001, 4'b1001,  3,  0};
        tbl[7]  = '{4'hF, 1'b0, 4'b0110, 4'b0011,  1,  2};
        tbl[8]  = '{4'h1, 1'b0, 4'b0001, 4'b0001,  0, -1};
        tbl[9]  = '{4'h8, 1'b0, 4'b1000, 4'b1000,  3, -1};
        tbl[10] = '{4'h6, 1'b0, 4'b0110, 4'b0110,  1,  2};
        tbl[11] = '{4'h7, 1'b0, 4'b0011, 4'b0011,  0,  1};
        tbl[12] = '{4'h0, 1'b0, 4'b0000, 4'b0000, -1, -1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = 4'hF;
        src_tag   = 16'h3210;
        src_data  = 64'h4444_3333_2222_1111;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(src_grant), 32'h0);
        check("reset_valid", 32'(cdb_valid), 32'h0);
        check("reset_tag", 32'(cdb_tag), 32'h0);
        src_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i > 0) pop_lanes(i - 1);
            for (int s = 0; s < 4; s++) begin
                tg[s] = 4'((i * 4 + s) % 16);
                dt[s] = 16'($urandom);
            end
            if (i == 5) dt[2] = 16'hBEEF;
            src_tag   = {tg[3], tg[2], tg[1], tg[0]};
            src_data  = {dt[3], dt[2], dt[1], dt[0]};
            src_valid = tbl[i].v;
            flush     = tbl[i].fl;
            #1;
            check($sformatf("grant[%0d]", i), 32'(src_grant), 32'(tbl[i].g));
            check($sformatf("fx_grant[%0d]", i), 32'(fx_grant), 32'(tbl[i].gf));
            e = '{2'b00, 8'h00, 32'h0};
            if (tbl[i].l0 >= 0) begin
                e.v[0]     = 1'b1;
                e.t[3:0]   = tg[tbl[i].l0];
                e.d[15:0]  = dt[tbl[i].l0];
            end
            if (tbl[i].l1 >= 0) begin
                e.v[1]     = 1'b1;
                e.t[7:4]   = tg[tbl[i].l1];
                e.d[31:16] = dt[tbl[i].l1];
            end
            sbq.push_back(e);
        end
        @(negedge clk);
        pop_lanes(12);
        flush = 1'b0;

        // rr_ptr left at 2; move it to 3, then reset mid-flight
        src_valid = 4'b0100;
        src_tag   = 16'h0A00;
        src_data  = 64'h0000_BEEF_0000_0000;
        #1;
        check("pre_rst_grant", 32'(src_grant), 32'b0100);
        @(negedge clk);
        check("pre_rst_lane", 32'(cdb_valid), 32'b01);
        src_valid = 4'hF;
        src_tag   = 16'h4321;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_valid", 32'(cdb_valid), 32'h0);
        check("mid_rst_data", cdb_data, 32'h0);
        check("mid_rst_grant", 32'(src_grant), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'(src_grant), 32'b0011);
        @(negedge clk);
        check("post_rst_tag", 32'(cdb_tag), 32'h21);
        check("post_rst_grant2", 32'(src_grant), 32'b1100);

        // fixed priority never rotates under continuous load
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("fx_hold[%0d]", c), 32'(fx_grant), 32'b0011);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
